// File: rtl/interval_timer_pkg.sv
// Shared types and defaults for the interval timer controller.
// State encoding plus default datapath widths.
package interval_timer_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_PRE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle between system logic and the timer.
// master drives requests and config; slave is the timer.
interface interval_timer_ctrl_if
    import interval_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRE_W = DEF_PRE_W
);

    logic             start;
    logic             stop;
    logic [WIDTH-1:0] load_val;
    logic [PRE_W-1:0] prescale;
    logic             periodic;
    logic             irq_ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             irq;
    logic             overrun;

    modport master (
        output start,
        output stop,
        output load_val,
        output prescale,
        output periodic,
        output irq_ack,
        input  count,
        input  busy,
        input  done,
        input  irq,
        input  overrun
    );

    modport slave (
        input  start,
        input  stop,
        input  load_val,
        input  prescale,
        input  periodic,
        input  irq_ack,
        output count,
        output busy,
        output done,
        output irq,
        output overrun
    );

endinterface

// File: rtl/interval_timer_prescaler.sv
// Tick divider: one tick every div+1 enabled cycles.
// clr restarts the divide phase from zero.
module interval_timer_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt;

    assign tick = en && (pre_cnt == div);

    // Divide counter: wraps to zero on each tick.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            if (tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: FSM, owned up-counter,
// terminal-count reload and sticky irq/overrun flags.
module interval_timer_ctrl
    import interval_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    interval_timer_ctrl_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic [PRE_W-1:0] prescale_q;
    logic             periodic_q;
    logic             done_q;
    logic             irq_q;
    logic             overrun_q;

    logic accept;
    logic halt;
    logic run_en;
    logic tick;
    logic hit;
    logic expire;

    // Start only from a quiescent state; stop always wins.
    assign accept = (state_q != RUN) && bus.start && !bus.stop;
    assign halt   = (state_q == RUN) && bus.stop;
    assign run_en = (state_q == RUN) && !bus.stop;
    assign hit    = (count_q == limit_q);
    assign expire = run_en && tick && hit;

    interval_timer_prescaler #(
        .PRE_W (PRE_W)
    ) u_pre (
        .clk   (clk),
        .reset (reset),
        .clr   (accept || halt),
        .en    (run_en),
        .div   (prescale_q),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one-shot parks in DONE at expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (expire && !periodic_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Configuration is captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            limit_q    <= '0;
            prescale_q <= '0;
            periodic_q <= 1'b0;
        end else if (accept) begin
            limit_q    <= bus.load_val;
            prescale_q <= bus.prescale;
            periodic_q <= bus.periodic;
        end
    end

    // Counter: never passes limit_q, so no overflow at max limit.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            count_q <= '0;
        end else if (run_en && tick) begin
            if (!hit) begin
                count_q <= count_q + WIDTH'(1);
            end else if (periodic_q) begin
                count_q <= '0;
            end
        end
    end

    // Flags: an expiry beats a same-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= expire;
            if (expire) begin
                irq_q <= 1'b1;
                if (irq_q) begin
                    overrun_q <= 1'b1;
                end
            end else if (bus.irq_ack) begin
                irq_q     <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.busy    = (state_q == RUN);
    assign bus.done    = done_q;
    assign bus.irq     = irq_q;
    assign bus.overrun = overrun_q;

endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
Controller that sequences a 16-bit up-counter as a programmable interval timer: start/stop control, prescaled count enable, terminal-count detection, one-shot or periodic reload, and a sticky interrupt with acknowledge handshake. It sits between the system control logic and the counter datapath. It owns the counter register, so it is the only block that loads, enables or clears it.

Parameters:
WIDTH, 16, counter and limit width in bits
PRE_W, 8, prescaler width in bits

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  reset, synchronous, active-high
start  in  1  start request; sampled every cycle
stop  in  1  stop request; sampled every cycle
load_val  in  WIDTH  terminal count; latched on an accepted start
prescale  in  PRE_W  tick divider minus 1; latched on an accepted start
periodic  in  1  1 = auto-reload, 0 = one-shot; latched on an accepted start
irq_ack  in  1  clears irq and overrun
count  out  WIDTH  current counter value
busy  out  1  high in RUN
done  out  1  one-cycle pulse per expiry
irq  out  1  sticky expiry flag
overrun  out  1  sticky flag: expiry occurred while irq was already set

Behaviour:
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, and count, prescaler counter, latched config, done, irq and overrun all become 0. A reset mid-RUN aborts immediately.
- Accepted start (state IDLE or DONE, start=1, stop=0):
  - latch limit_q, prescale_q and periodic_q;
  - clear count and the prescaler counter;
  - state becomes RUN at that same edge.
- start while in RUN is ignored. Restart requires stop then start.
- Prescaler (RUN only):
  - tick = (pre_cnt == prescale_q);
  - on tick, pre_cnt becomes 0; otherwise pre_cnt increments;
  - prescale_q=0 gives a tick every cycle.
- On tick in RUN:
  - count != limit_q: count increments.
  - count == limit_q: expiry. done=1 for the next cycle only, and irq is set.
    - periodic_q=1: count becomes 0 and the state stays RUN.
    - periodic_q=0: count holds at limit_q and the state becomes DONE.
- Period is (limit_q+1)*(prescale_q+1) cycles.
  - First expiry edge is (limit_q+1)*(prescale_q+1) edges after the start edge.
  - load_val=0 means an expiry on every tick.
  - No wrap past limit_q. With limit_q=16'hFFFF, expiry returns count to 0 and the increment never overflows.
- stop in RUN: state becomes IDLE at the next edge. count holds its value and pre_cnt clears. stop has priority over a tick in the same cycle, so no expiry occurs and done stays 0.
- stop in IDLE or DONE: no effect. start and stop together: stop wins and the state does not change.
- irq/overrun, evaluated each edge:
  - an expiry with irq already 1 sets overrun;
  - irq_ack clears both flags;
  - set wins over irq_ack in the same cycle, so expiry+ack leaves irq=1 and overrun=0.
- busy = (state==RUN), combinational from the state register. done, irq and overrun are registered.
- Configuration inputs are ignored outside an accepted start.

Decomposition:
- Package interval_timer_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default WIDTH and PRE_W localparams.
- Sub-module interval_timer_prescaler (PRE_W): inputs clk, reset, clr, en, div; output tick.
- The FSM, counter and flags stay in the top-level block.

Test Plan:
- One-shot basic: prescale=0, load_val=3, periodic=0, start pulse. count reads 1,2,3 after successive edges; done pulses on the 4th edge after start; irq=1; state DONE; count holds 3; busy=0.
- Periodic with prescale: prescale=2, load_val=1, periodic=1. done pulses every 6 cycles, and count sequence 0,0,0,1,1,1,0 repeats. Without irq_ack, the second expiry sets overrun=1.
- Stop and tick collide: prescale=0, load_val=5, stop asserted on the expiry cycle. No done pulse, irq=0, state IDLE, count=5. A new start with load_val=2 then expires after 3 cycles.
- Start/stop and ack priority:
  - start with stop in IDLE leaves the state in IDLE;
  - start in RUN leaves limit_q unchanged;
  - irq_ack on the expiry cycle leaves irq=1 and overrun=0;
  - a later lone irq_ack clears irq.
- Boundaries: load_val=0, prescale=0, periodic=1 gives done on every cycle and count stays 0. load_val=16'hFFFF, prescale=0 gives the first expiry at 65536 cycles, with count returning to 0.
- Reset mid-run: reset asserted during RUN with irq=1. On the next edge all outputs are 0 and the state is IDLE, and no done pulse follows reset release.
